spi_req_arbiter: RTL
====================

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 64, number of WAIT cycles allowed for spi_done before abort (legal range 2..255).
REQ-002 Clock: clk  input  1  system clock; all logic on rising edge.
REQ-003 Reset: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req0  input  1  requester 0 transfer request, held high until ack0 is seen.
REQ-005 Port: req1  input  1  requester 1 transfer request, held high until ack1 is seen.
REQ-006 Port: data0  input  8  requester 0 byte, stable while req0 is high.
REQ-007 Port: data1  input  8  requester 1 byte, stable while req1 is high.
REQ-008 Port: spi_done  input  1  one-cycle pulse from the SPI transmit engine marking end of the byte.
REQ-009 Port: spi_start  output  1  one-cycle launch pulse to the SPI transmit engine.
REQ-010 Port: spi_data  output  8  latched byte of the granted requester, MSB sent first by the engine.
REQ-011 Port: cs_n  output  2  active-low slave select, bit i for requester i.
REQ-012 Port: gnt  output  2  one-hot grant, bit i for requester i.
REQ-013 Port: ack  output  2  one-cycle completion pulse, bit i for requester i.
REQ-014 Port: err  output  1  high in the same cycle as ack when the transfer timed out.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT and RELEASE; all outputs are registered.
REQ-016 IDLE with no request SHALL stay in IDLE; with any request it SHALL go to LAUNCH.
- On entry to LAUNCH: winner's bit set in gnt and cs_n; winner's data latched into spi_data.
REQ-017 LAUNCH SHALL last one cycle with spi_start=1, then go to WAIT.
- Latency: request sampled in IDLE at cycle N gives spi_start high at cycle N+1.
REQ-018 WAIT behaviour:
- Timer cleared on entry and incremented each cycle.
- spi_done high: go to RELEASE.
- Timer reaching TIMEOUT-1 without spi_done: go to RELEASE with err flagged.
REQ-019 If spi_done and timeout occur in the same cycle, spi_done SHALL win and err SHALL be 0.
REQ-020 RELEASE SHALL last one cycle and then return to IDLE.
- ack pulses for the granted requester; err is valid in the same cycle.
- gnt=00 and cs_n=11.
- Last-served pointer updated to the granted requester.
REQ-021 spi_done SHALL be ignored in IDLE, LAUNCH and RELEASE.
REQ-022 Tie-break, both requests in IDLE:
- Round-robin: grant goes to the requester that is not the last-served one.
- Single request: granted regardless of the pointer.
REQ-023 Back-to-back transfers SHALL pass through IDLE, giving a minimum of 4 cycles per transfer plus the engine time.
REQ-024 A request that drops before its grant SHALL be ignored.
- Once granted, the transfer SHALL complete even if the request drops.
REQ-025 gnt SHALL never have both bits set, and at most one bit of cs_n SHALL be low.

Reset
REQ-026 rst SHALL force:
- state IDLE; gnt=00, ack=00, err=0, spi_start=0.
- cs_n=11, spi_data=8'h00, timer=0.
- Last-served pointer = requester 1, so requester 0 wins the first tie.
REQ-027 rst asserted mid-transfer SHALL abort within one cycle with no ack, and cs_n SHALL go to 11 at once.
- The SPI engine shares rst.

Configuration
REQ-028 Macro: SPI_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins ties and the pointer is unused.
- Undefined: round-robin per REQ-022.

Verification
REQ-029 req0=1, data0=8'hA5, spi_done 10 cycles after spi_start -> gnt=01, cs_n=10, spi_data=A5, ack=01 with err=0, then gnt=00, cs_n=11.
REQ-030 req0 and req1 held high for three transfers after reset -> grants 0,1,0 (round-robin); with SPI_ARB_FIXED_PRIO_EN -> 0,0,0.
REQ-031 req1=1, data1=8'h3C, spi_done never pulsed, TIMEOUT=64 -> ack=10 with err=1 exactly 64 cycles after WAIT entry.
REQ-032 spi_done arrives in the last timeout cycle -> ack pulse with err=0.
REQ-033 rst pulsed during WAIT -> next cycle gnt=00, cs_n=11, no ack; a later req0 is served normally.
REQ-034 spi_done pulsed while in IDLE with no request -> no state change and no ack.

Source files
------------

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: two-requester arbiter in front of a single SPI transmit
// engine. A four-state FSM (IDLE -> LAUNCH -> WAIT -> RELEASE) grants one
// requester, launches its byte, waits for spi_done or a timeout, then pulses
// ack for that requester.
// Configuration macro SPI_ARB_FIXED_PRIO_EN: when defined, requester 0 always
// wins ties. When undefined (the default), ties are decided round-robin
// against a last-served pointer.
//
// Handshake: req0/req1 are level requests held until the matching ack pulse.
// The engine sees a one-cycle spi_start and answers with a one-cycle
// spi_done. spi_done only counts while the FSM is in WAIT.
module spi_req_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       spi_done,
    output logic       spi_start,
    output logic [7:0] spi_data,
    output logic [1:0] cs_n,
    output logic [1:0] gnt,
    output logic [1:0] ack,
    output logic       err,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Timer value in the last WAIT cycle before giving up.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] timer;
    logic       win;   // 0: requester 0 wins, 1: requester 1 wins

`ifndef SPI_ARB_FIXED_PRIO_EN
    logic       last_srv;  // index of the most recently served requester
`endif

    assign dbg_state = state;

    // Pick the winner among the requesters active this cycle.
    always_comb begin
        win = 1'b0;
`ifdef SPI_ARB_FIXED_PRIO_EN
        win = req0 ? 1'b0 : 1'b1;
`else
        if (req0 && req1) begin
            win = ~last_srv;
        end else begin
            win = req0 ? 1'b0 : 1'b1;
        end
`endif
    end

    // Arbiter FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            cs_n      <= 2'b11;
            ack       <= 2'b00;
            err       <= 1'b0;
            spi_start <= 1'b0;
            spi_data  <= 8'h00;
            timer     <= 8'd0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            last_srv  <= 1'b1;
`endif
        end else begin
            ack       <= 2'b00;
            err       <= 1'b0;
            spi_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state     <= LAUNCH;
                        gnt       <= win ? 2'b10 : 2'b01;
                        cs_n      <= win ? 2'b01 : 2'b10;
                        spi_data  <= win ? data1 : data0;
                        spi_start <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state <= WAIT;
                    timer <= 8'd0;
                end
                WAIT: begin
                    // spi_done takes precedence over a coincident timeout.
                    if (spi_done || (timer == TMO_LAST)) begin
                        state <= RELEASE;
                        ack   <= gnt;
                        err   <= ~spi_done;
                        gnt   <= 2'b00;
                        cs_n  <= 2'b11;
`ifndef SPI_ARB_FIXED_PRIO_EN
                        last_srv <= gnt[1];
`endif
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
